// File: rtl/memory_arbiter.sv
// Arbitrates one synchronous memory port between the CPU and a read-only display
// fetch engine: display has priority, capped by a burst limit while the CPU waits.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH     = 16,
  parameter int DATA_WIDTH        = 16,
  parameter int MAX_DISPLAY_BURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_request,
  input  logic                     cpu_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0]    cpu_write_data,
  output logic                     cpu_grant,
  output logic                     cpu_read_valid,
  output logic [DATA_WIDTH-1:0]    cpu_read_data,
  input  logic                     display_request,
  input  logic [ADDRESS_WIDTH-1:0] display_address,
  output logic                     display_grant,
  output logic                     display_read_valid,
  output logic [DATA_WIDTH-1:0]    display_read_data,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic                     memory_write_enable,
  output logic [DATA_WIDTH-1:0]    memory_write_data,
  input  logic [DATA_WIDTH-1:0]    memory_read_data
);

  localparam int STREAK_W = $clog2(MAX_DISPLAY_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DISPLAY_BURST);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                cpu_pending_q, cpu_pending_d;
  logic                display_pending_q, display_pending_d;
  logic                burst_done;

  // Grant decision: display wins contention until the burst budget is spent.
  always_comb begin
    burst_done    = (streak_q >= STREAK_MAX);
    cpu_grant     = 1'b0;
    display_grant = 1'b0;
    if (!reset) begin
      if (display_request && (!cpu_request || !burst_done)) begin
        display_grant = 1'b1;
      end else if (cpu_request) begin
        cpu_grant = 1'b1;
      end
    end
  end

  always_comb begin
    memory_address      = cpu_address;
    memory_write_enable = 1'b0;
    memory_write_data   = cpu_write_data;
    if (display_grant) begin
      memory_address = display_address;
    end else if (cpu_grant) begin
      memory_write_enable = cpu_write_enable;
    end
  end

  // The streak only counts display grants that actually made the CPU wait.
  always_comb begin
    streak_d = streak_q;
    if (!cpu_request || cpu_grant) begin
      streak_d = '0;
    end else if (display_grant && !burst_done) begin
      streak_d = streak_q + STREAK_W'(1);
    end
    cpu_pending_d     = cpu_grant & ~cpu_write_enable;
    display_pending_d = display_grant;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak_q          <= '0;
      cpu_pending_q     <= 1'b0;
      display_pending_q <= 1'b0;
    end else begin
      streak_q          <= streak_d;
      cpu_pending_q     <= cpu_pending_d;
      display_pending_q <= display_pending_d;
    end
  end

  assign cpu_read_valid     = cpu_pending_q;
  assign display_read_valid = display_pending_q;
  assign cpu_read_data      = memory_read_data;
  assign display_read_data  = memory_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter against a transaction-level
// model (wait counter, shadow memory, queue of expected read returns).
module tb_memory_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_request, cpu_write_enable;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_write_data;
  logic          cpu_grant, cpu_read_valid;
  logic [DW-1:0] cpu_read_data;
  logic          display_request;
  logic [AW-1:0] display_address;
  logic          display_grant, display_read_valid;
  logic [DW-1:0] display_read_data;
  logic [AW-1:0] memory_address;
  logic          memory_write_enable;
  logic [DW-1:0] memory_write_data;
  logic [DW-1:0] memory_read_data = '0;

  always #5 clock = ~clock;

  memory_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DISPLAY_BURST(MAXB)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_request(cpu_request), .cpu_write_enable(cpu_write_enable),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_grant(cpu_grant), .cpu_read_valid(cpu_read_valid),
    .cpu_read_data(cpu_read_data),
    .display_request(display_request), .display_address(display_address),
    .display_grant(display_grant), .display_read_valid(display_read_valid),
    .display_read_data(display_read_data),
    .memory_address(memory_address), .memory_write_enable(memory_write_enable),
    .memory_write_data(memory_write_data), .memory_read_data(memory_read_data)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  // Synchronous RAM: data for the address issued this cycle appears next cycle.
  logic [DW-1:0] ram    [0:65535];
  bit            ram_wr [0:65535];
  always @(posedge clock) begin
    memory_read_data <= ram_wr[memory_address] ? ram[memory_address] : init_val(memory_address);
    if (memory_write_enable) begin
      ram[memory_address]    <= memory_write_data;
      ram_wr[memory_address] <= 1'b1;
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem    [0:65535];
  bit            ref_wr     [0:65535];
  typedef struct { bit is_cpu; logic [DW-1:0] data; } ret_t;
  ret_t ret_q[$];
  int   m_wait;
  int   cpu_wait;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic step(input bit rst, input bit creq, input bit cwe,
                      input logic [AW-1:0] caddr, input logic [DW-1:0] cdata,
                      input bit dreq, input logic [AW-1:0] daddr,
                      output bit g_c, output bit g_d,
                      output bit v_c, output logic [DW-1:0] d_c);
    bit   ec, ed, ecv, edv;
    logic [DW-1:0] ecd, edd;
    ret_t r;
    reset = rst; cpu_request = creq; cpu_write_enable = cwe;
    cpu_address = caddr; cpu_write_data = cdata;
    display_request = dreq; display_address = daddr;
    #2;
    ecv = 1'b0; edv = 1'b0; ecd = '0; edd = '0;
    if (ret_q.size() > 0) begin
      r = ret_q.pop_front();
      if (!rst) begin
        if (r.is_cpu) begin ecv = 1'b1; ecd = r.data; end
        else begin edv = 1'b1; edd = r.data; end
      end
    end
    if (rst) begin
      ec = 1'b0; ed = 1'b0;
    end else begin
      ed = dreq && (!creq || m_wait < MAXB);
      ec = creq && !ed;
    end
    g_c = cpu_grant; g_d = display_grant; v_c = cpu_read_valid; d_c = cpu_read_data;
    chk("cpu_grant", cpu_grant, ec);
    chk("display_grant", display_grant, ed);
    chk("mem_addr", memory_address, ed ? daddr : caddr);
    chk("mem_we", memory_write_enable, ec && cwe);
    chk("mem_wdata", memory_write_data, cdata);
    chk("cpu_valid", cpu_read_valid, ecv);
    chk("disp_valid", display_read_valid, edv);
    if (ecv) chk("cpu_rdata", cpu_read_data, ecd);
    if (edv) chk("disp_rdata", display_read_data, edd);
    if (!rst && creq && !cpu_grant) cpu_wait++;
    else cpu_wait = 0;
    chk("cpu_wait_bound", cpu_wait <= MAXB, 1);
    if (rst) begin
      m_wait = 0;
    end else begin
      if (ed) ret_q.push_back('{1'b0, ref_rd(daddr)});
      if (ec && !cwe) ret_q.push_back('{1'b1, ref_rd(caddr)});
      if (ec && cwe) begin ref_mem[caddr] = cdata; ref_wr[caddr] = 1'b1; end
      if (!creq || ec) m_wait = 0;
      else if (ed && m_wait < MAXB) m_wait++;
    end
    @(posedge clock);
    #1;
  endtask

  bit            gc, gd, vc;
  logic [DW-1:0] dc;

  initial begin
    m_wait = 0; cpu_wait = 0;

    // Reset held with both requests high
    step(1, 1, 0, 16'h0010, 16'h0, 1, 16'h0020, gc, gd, vc, dc);
    step(1, 1, 0, 16'h0010, 16'h0, 1, 16'h0020, gc, gd, vc, dc);
    chk("rst_cpu_grant", gc, 0);
    chk("rst_disp_grant", gd, 0);
    step(0, 1, 0, 16'h0010, 16'h0, 1, 16'h0020, gc, gd, vc, dc);
    chk("post_rst_disp_first", gd, 1);
    step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, vc, dc);

    // CPU write then read back
    step(0, 1, 1, 16'h0100, 16'hBEEF, 0, 16'h0, gc, gd, vc, dc);
    chk("wr_granted", gc, 1);
    step(0, 1, 0, 16'h0100, 16'h0, 0, 16'h0, gc, gd, vc, dc);
    chk("rd_granted", gc, 1);
    chk("wr_no_valid", vc, 0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, vc, dc);
    chk("rd_valid", vc, 1);
    chk("rd_data", dc, 16'hBEEF);

    // Continuous contention: D,D,D,D,C repeating
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 16'h0040 + 16'(i), 16'h0, 1, 16'h3000 + 16'(i), gc, gd, vc, dc);
      chk("burst_pattern_d", gd, (i % 5) != 4);
      chk("burst_pattern_c", gc, (i % 5) == 4);
    end
    step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, vc, dc);

    // Back-to-back display reads, CPU idle
    step(0, 0, 0, 16'h0, 16'h0, 1, 16'h2000, gc, gd, vc, dc);
    step(0, 0, 0, 16'h0, 16'h0, 1, 16'h2001, gc, gd, vc, dc);
    chk("disp_b2b_cpu_valid", vc, 0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, vc, dc);
    chk("disp_b2b_cpu_valid2", vc, 0);

    // CPU read followed by reset: read is lost
    step(0, 1, 0, 16'h0100, 16'h0, 0, 16'h0, gc, gd, vc, dc);
    chk("pre_rst_rd_grant", gc, 1);
    step(1, 0, 0, 16'h0100, 16'h0, 0, 16'h0, gc, gd, vc, dc);
    chk("rst_kills_valid", vc, 0);
    step(0, 0, 0, 16'h0100, 16'h0, 0, 16'h0, gc, gd, vc, dc);
    chk("rst_kills_valid2", vc, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 16'h0100, 16'h0, 1, 16'h0200, gc, gd, vc, dc);
      chk("post_rst_burst", gc, i == 4);
    end

    // CPU drops after two display grants; streak restarts
    step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, vc, dc);
    step(0, 1, 0, 16'h0050, 16'h0, 1, 16'h0060, gc, gd, vc, dc);
    step(0, 1, 0, 16'h0050, 16'h0, 1, 16'h0061, gc, gd, vc, dc);
    step(0, 0, 0, 16'h0050, 16'h0, 1, 16'h0062, gc, gd, vc, dc);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 16'h0051, 16'h0, 1, 16'h0063 + 16'(i), gc, gd, vc, dc);
      chk("drop_full_burst", gc, i == 4);
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           16'($urandom_range(0, 63)), 16'($urandom), $urandom_range(0, 3) != 0,
           16'($urandom_range(0, 63)), gc, gd, vc, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
